// File: rtl/branch_resolve_pipe.sv
// Two-stage branch resolution: S1 registers the offered op, S2 holds the resolved result.
// Handles conditional branches, JAL, JALR and AUIPC, with mispredict/redirect reporting and perf counters.
module branch_resolve_pipe #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ROB_SIZE      = 256,
  parameter int unsigned PHYS_REG_SIZE = 256,
  parameter int unsigned C_EXT         = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [3:0]                       in_uop,
  input  logic [XLEN-1:0]                  in_rs1,
  input  logic [XLEN-1:0]                  in_rs2,
  input  logic [XLEN-1:0]                  in_pc,
  input  logic [XLEN-1:0]                  in_offset,
  input  logic                             in_compressed,
  input  logic                             in_pred_taken,
  input  logic [XLEN-1:0]                  in_pred_target,
  input  logic [$clog2(ROB_SIZE)-1:0]      in_rob_entry,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] in_dest_tag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(ROB_SIZE)-1:0]      out_rob_entry,
  output logic [$clog2(PHYS_REG_SIZE)-1:0] out_dest_tag,
  output logic                             out_taken,
  output logic [XLEN-1:0]                  out_target,
  output logic                             out_link,
  output logic [XLEN-1:0]                  out_link_val,
  output logic                             out_mispredict,
  output logic [XLEN-1:0]                  out_redirect_pc,
  output logic                             out_misaligned,
  output logic                             out_illegal,
  output logic [CNT_W-1:0]                 branch_count,
  output logic [CNT_W-1:0]                 mispredict_count
);

  localparam int unsigned ROB_W  = $clog2(ROB_SIZE);
  localparam int unsigned PREG_W = $clog2(PHYS_REG_SIZE);

  localparam logic [3:0] UOP_BEQ   = 4'd0;
  localparam logic [3:0] UOP_BNE   = 4'd1;
  localparam logic [3:0] UOP_BLT   = 4'd4;
  localparam logic [3:0] UOP_BGE   = 4'd5;
  localparam logic [3:0] UOP_BLTU  = 4'd6;
  localparam logic [3:0] UOP_BGEU  = 4'd7;
  localparam logic [3:0] UOP_JAL   = 4'd8;
  localparam logic [3:0] UOP_JALR  = 4'd9;
  localparam logic [3:0] UOP_AUIPC = 4'd10;

  logic              r_s1_valid;
  logic [3:0]        r_s1_uop;
  logic [XLEN-1:0]   r_s1_rs1, r_s1_rs2, r_s1_pc, r_s1_offset, r_s1_pred_target;
  logic              r_s1_compressed, r_s1_pred_taken;
  logic [ROB_W-1:0]  r_s1_rob;
  logic [PREG_W-1:0] r_s1_dest;
  logic              r_out_cfi;

  logic              w_s2_free, w_s1_adv, w_in_fire, w_out_fire;
  logic              w_eq, w_slt, w_ult;
  logic [XLEN-1:0]   w_ilen, w_pc_ilen, w_pc_off, w_rs1_off;
  logic              w_taken, w_link, w_cfi, w_illegal;
  logic [XLEN-1:0]   w_target, w_link_val;
  logic              w_mispredict, w_misaligned;
  logic [XLEN-1:0]   w_redirect;

  assign w_s2_free  = !out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = !r_s1_valid || w_s2_free;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  assign w_eq      = (r_s1_rs1 == r_s1_rs2);
  assign w_slt     = ($signed(r_s1_rs1) < $signed(r_s1_rs2));
  assign w_ult     = (r_s1_rs1 < r_s1_rs2);
  assign w_ilen    = r_s1_compressed ? XLEN'(2) : XLEN'(4);
  assign w_pc_ilen = r_s1_pc + w_ilen;
  assign w_pc_off  = r_s1_pc + r_s1_offset;
  assign w_rs1_off = r_s1_rs1 + r_s1_offset;

  // Resolve the S1 op into outcome, target and link value
  always_comb begin
    w_taken    = 1'b0;
    w_target   = w_pc_off;
    w_link     = 1'b0;
    w_link_val = '0;
    w_cfi      = 1'b0;
    w_illegal  = 1'b0;
    case (r_s1_uop)
      UOP_BEQ:  begin w_taken = w_eq;   w_cfi = 1'b1; end
      UOP_BNE:  begin w_taken = !w_eq;  w_cfi = 1'b1; end
      UOP_BLT:  begin w_taken = w_slt;  w_cfi = 1'b1; end
      UOP_BGE:  begin w_taken = !w_slt; w_cfi = 1'b1; end
      UOP_BLTU: begin w_taken = w_ult;  w_cfi = 1'b1; end
      UOP_BGEU: begin w_taken = !w_ult; w_cfi = 1'b1; end
      UOP_JAL: begin
        w_taken    = 1'b1;
        w_cfi      = 1'b1;
        w_link     = 1'b1;
        w_link_val = w_pc_ilen;
      end
      UOP_JALR: begin
        w_taken    = 1'b1;
        w_cfi      = 1'b1;
        w_target   = {w_rs1_off[XLEN-1:1], 1'b0};
        w_link     = 1'b1;
        w_link_val = w_pc_ilen;
      end
      UOP_AUIPC: begin
        w_link     = 1'b1;
        w_link_val = w_pc_off;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_mispredict = w_cfi && ((w_taken != r_s1_pred_taken) ||
                                  (w_taken && (w_target != r_s1_pred_target)));
  assign w_redirect   = w_taken ? w_target : w_pc_ilen;
  assign w_misaligned = w_taken && ((C_EXT != 0) ? w_target[0] : (|w_target[1:0]));

  // S1 capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid       <= 1'b0;
      r_s1_uop         <= '0;
      r_s1_rs1         <= '0;
      r_s1_rs2         <= '0;
      r_s1_pc          <= '0;
      r_s1_offset      <= '0;
      r_s1_compressed  <= 1'b0;
      r_s1_pred_taken  <= 1'b0;
      r_s1_pred_target <= '0;
      r_s1_rob         <= '0;
      r_s1_dest        <= '0;
    end else begin
      if (flush)          r_s1_valid <= 1'b0;
      else if (w_in_fire) r_s1_valid <= 1'b1;
      else if (w_s1_adv)  r_s1_valid <= 1'b0;
      if (w_in_fire && !flush) begin
        r_s1_uop         <= in_uop;
        r_s1_rs1         <= in_rs1;
        r_s1_rs2         <= in_rs2;
        r_s1_pc          <= in_pc;
        r_s1_offset      <= in_offset;
        r_s1_compressed  <= in_compressed;
        r_s1_pred_taken  <= in_pred_taken;
        r_s1_pred_target <= in_pred_target;
        r_s1_rob         <= in_rob_entry;
        r_s1_dest        <= in_dest_tag;
      end
    end
  end

  // S2 output registers; data frozen while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_rob_entry   <= '0;
      out_dest_tag    <= '0;
      out_taken       <= 1'b0;
      out_target      <= '0;
      out_link        <= 1'b0;
      out_link_val    <= '0;
      out_mispredict  <= 1'b0;
      out_redirect_pc <= '0;
      out_misaligned  <= 1'b0;
      out_illegal     <= 1'b0;
      r_out_cfi       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_s1_adv) begin
      out_valid       <= 1'b1;
      out_rob_entry   <= r_s1_rob;
      out_dest_tag    <= r_s1_dest;
      out_taken       <= w_taken;
      out_target      <= w_target;
      out_link        <= w_link;
      out_link_val    <= w_link_val;
      out_mispredict  <= w_mispredict;
      out_redirect_pc <= w_redirect;
      out_misaligned  <= w_misaligned;
      out_illegal     <= w_illegal;
      r_out_cfi       <= w_cfi;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating perf counters; a consume in the flush cycle still counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (w_out_fire && r_out_cfi) begin
      if (branch_count != '1) branch_count <= branch_count + CNT_W'(1);
      if (out_mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Directed bench for branch_resolve_pipe: two instances share stimulus,
// A with default parameters, B with C_EXT=0 and a 4-bit counter.
module tb_branch_resolve_pipe;
  localparam logic [3:0] UOP_BEQ = 4'd0, UOP_BNE = 4'd1, UOP_BLT = 4'd4, UOP_BGE = 4'd5,
                         UOP_BLTU = 4'd6, UOP_BGEU = 4'd7, UOP_JAL = 4'd8, UOP_JALR = 4'd9,
                         UOP_AUIPC = 4'd10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_uop = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_offset = '0, in_pred_target = '0;
  logic        in_compressed = 1'b0, in_pred_taken = 1'b0;
  logic [7:0]  in_rob_entry = '0, in_dest_tag = '0;

  logic        a_in_ready, a_out_valid, a_out_taken, a_out_link, a_out_mispredict, a_out_misaligned, a_out_illegal;
  logic [7:0]  a_out_rob_entry, a_out_dest_tag;
  logic [31:0] a_out_target, a_out_link_val, a_out_redirect_pc, a_branch_count, a_mispredict_count;
  logic        b_in_ready, b_out_valid, b_out_taken, b_out_link, b_out_mispredict, b_out_misaligned, b_out_illegal;
  logic [7:0]  b_out_rob_entry, b_out_dest_tag;
  logic [31:0] b_out_target, b_out_link_val, b_out_redirect_pc;
  logic [3:0]  b_branch_count, b_mispredict_count;

  branch_resolve_pipe #(.XLEN(32), .ROB_SIZE(256), .PHYS_REG_SIZE(256), .C_EXT(1), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready), .in_uop(in_uop),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_offset(in_offset), .in_compressed(in_compressed),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_rob_entry(in_rob_entry),
    .in_dest_tag(in_dest_tag), .out_valid(a_out_valid), .out_ready(out_ready), .out_rob_entry(a_out_rob_entry),
    .out_dest_tag(a_out_dest_tag), .out_taken(a_out_taken), .out_target(a_out_target), .out_link(a_out_link),
    .out_link_val(a_out_link_val), .out_mispredict(a_out_mispredict), .out_redirect_pc(a_out_redirect_pc),
    .out_misaligned(a_out_misaligned), .out_illegal(a_out_illegal), .branch_count(a_branch_count),
    .mispredict_count(a_mispredict_count));

  branch_resolve_pipe #(.XLEN(32), .ROB_SIZE(256), .PHYS_REG_SIZE(256), .C_EXT(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready), .in_uop(in_uop),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_offset(in_offset), .in_compressed(in_compressed),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_rob_entry(in_rob_entry),
    .in_dest_tag(in_dest_tag), .out_valid(b_out_valid), .out_ready(out_ready), .out_rob_entry(b_out_rob_entry),
    .out_dest_tag(b_out_dest_tag), .out_taken(b_out_taken), .out_target(b_out_target), .out_link(b_out_link),
    .out_link_val(b_out_link_val), .out_mispredict(b_out_mispredict), .out_redirect_pc(b_out_redirect_pc),
    .out_misaligned(b_out_misaligned), .out_illegal(b_out_illegal), .branch_count(b_branch_count),
    .mispredict_count(b_mispredict_count));

  int n_cmp = 0;
  int n_err = 0;
  int exp_bc = 0;
  int exp_mc = 0;

  typedef struct {
    logic [3:0]  uop;
    logic [31:0] rs1, rs2, pc, off;
    logic        comp, pt;
    logic [31:0] ptgt;
    logic        taken;
    logic [31:0] tgt;
    logic        link;
    logic [31:0] lval;
    logic        misp;
    logic [31:0] redir;
    logic        mis_a, mis_b, ill, cfi;
  } vec_t;

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] u, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] p, input logic [31:0] o, input logic c, input logic pt,
                        input logic [31:0] ptg, input logic [7:0] tag);
    in_uop = u; in_rs1 = r1; in_rs2 = r2; in_pc = p; in_offset = o;
    in_compressed = c; in_pred_taken = pt; in_pred_target = ptg;
    in_rob_entry = tag; in_dest_tag = ~tag;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_target !== 32'h0) begin n_err++; $display("FAIL rst_out_target: got %h want 0", a_out_target); end
    n_cmp++; if (a_branch_count !== 32'h0) begin n_err++; $display("FAIL rst_branch_count: got %0d want 0", a_branch_count); end
    n_cmp++; if (a_mispredict_count !== 32'h0) begin n_err++; $display("FAIL rst_mispredict_count: got %0d want 0", a_mispredict_count); end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    set_op(UOP_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0, 8'h11);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid: got %b want 1", a_out_valid); end
    n_cmp++; if (a_out_taken !== 1'b1) begin n_err++; $display("FAIL beq_taken: got %b want 1", a_out_taken); end
    n_cmp++; if (a_out_target !== 32'h120) begin n_err++; $display("FAIL beq_target: got %h want 120", a_out_target); end
    n_cmp++; if (a_out_mispredict !== 1'b1) begin n_err++; $display("FAIL beq_mispredict: got %b want 1", a_out_mispredict); end
    n_cmp++; if (a_out_redirect_pc !== 32'h120) begin n_err++; $display("FAIL beq_redirect: got %h want 120", a_out_redirect_pc); end
    n_cmp++; if (a_out_rob_entry !== 8'h11 || a_out_dest_tag !== 8'hEE) begin n_err++; $display("FAIL beq_tags: got %h/%h want 11/ee", a_out_rob_entry, a_out_dest_tag); end
    step();
    exp_bc = 1; exp_mc = 1;
    n_cmp++; if (a_branch_count !== 32'd1) begin n_err++; $display("FAIL beq_branch_count: got %0d want 1", a_branch_count); end
    n_cmp++; if (a_mispredict_count !== 32'd1) begin n_err++; $display("FAIL beq_mispredict_count: got %0d want 1", a_mispredict_count); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL beq_drained: got %b want 0", a_out_valid); end
  endtask

  task automatic test_ops();
    vec_t v[13];
    v[0]  = '{UOP_BLT,  32'hFFFFFFFF, 32'd1, 32'h300, 32'h10, 1'b0, 1'b1, 32'h310,
              1'b1, 32'h310, 1'b0, 32'h0, 1'b0, 32'h310, 1'b0, 1'b0, 1'b0, 1'b1};
    v[1]  = '{UOP_BLTU, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h10, 1'b0, 1'b0, 32'h0,
              1'b0, 32'h310, 1'b0, 32'h0, 1'b0, 32'h304, 1'b0, 1'b0, 1'b0, 1'b1};
    v[2]  = '{UOP_BGE,  32'd7, 32'd7, 32'h400, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h0,
              1'b1, 32'h3F0, 1'b0, 32'h0, 1'b1, 32'h3F0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[3]  = '{UOP_BNE,  32'd5, 32'd5, 32'h500, 32'h40, 1'b0, 1'b1, 32'h540,
              1'b0, 32'h540, 1'b0, 32'h0, 1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 1'b1};
    v[4]  = '{UOP_BGEU, 32'd1, 32'hFFFFFFFF, 32'h600, 32'h8, 1'b0, 1'b0, 32'h0,
              1'b0, 32'h608, 1'b0, 32'h0, 1'b0, 32'h604, 1'b0, 1'b0, 1'b0, 1'b1};
    v[5]  = '{UOP_JAL,  32'h0, 32'h0, 32'h700, 32'h100, 1'b0, 1'b1, 32'h800,
              1'b1, 32'h800, 1'b1, 32'h704, 1'b0, 32'h800, 1'b0, 1'b0, 1'b0, 1'b1};
    v[6]  = '{UOP_JAL,  32'h0, 32'h0, 32'h700, 32'h100, 1'b0, 1'b1, 32'h900,
              1'b1, 32'h800, 1'b1, 32'h704, 1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 1'b1};
    v[7]  = '{UOP_JALR, 32'h1003, 32'h0, 32'h200, 32'h0, 1'b1, 1'b1, 32'h1002,
              1'b1, 32'h1002, 1'b1, 32'h202, 1'b0, 32'h1002, 1'b0, 1'b1, 1'b0, 1'b1};
    v[8]  = '{UOP_AUIPC, 32'h0, 32'h0, 32'h1000, 32'h5000, 1'b0, 1'b1, 32'h0,
              1'b0, 32'h6000, 1'b1, 32'h6000, 1'b0, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b0};
    v[9]  = '{4'd3,     32'h0, 32'h0, 32'h2000, 32'h40, 1'b0, 1'b1, 32'h2040,
              1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h2004, 1'b0, 1'b0, 1'b1, 1'b0};
    v[10] = '{UOP_BEQ,  32'h0, 32'h0, 32'hFFFFFFF0, 32'h20, 1'b0, 1'b1, 32'h10,
              1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1};
    v[11] = '{UOP_JAL,  32'h0, 32'h0, 32'h100, 32'h3, 1'b1, 1'b1, 32'h103,
              1'b1, 32'h103, 1'b1, 32'h102, 1'b0, 32'h103, 1'b1, 1'b1, 1'b0, 1'b1};
    v[12] = '{UOP_BGEU, 32'd9, 32'd9, 32'h40, 32'h2, 1'b0, 1'b1, 32'h42,
              1'b1, 32'h42, 1'b0, 32'h0, 1'b0, 32'h42, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_op(v[i].uop, v[i].rs1, v[i].rs2, v[i].pc, v[i].off, v[i].comp, v[i].pt, v[i].ptgt, 8'(8'h20 + i));
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL op%0d_valid: got %b want 1", i, a_out_valid); end
      n_cmp++; if (a_out_taken !== v[i].taken) begin n_err++; $display("FAIL op%0d_taken: got %b want %b", i, a_out_taken, v[i].taken); end
      if (!v[i].ill) begin
        n_cmp++; if (a_out_target !== v[i].tgt) begin n_err++; $display("FAIL op%0d_target: got %h want %h", i, a_out_target, v[i].tgt); end
      end
      n_cmp++; if (a_out_link !== v[i].link) begin n_err++; $display("FAIL op%0d_link: got %b want %b", i, a_out_link, v[i].link); end
      if (v[i].link) begin
        n_cmp++; if (a_out_link_val !== v[i].lval) begin n_err++; $display("FAIL op%0d_link_val: got %h want %h", i, a_out_link_val, v[i].lval); end
      end
      n_cmp++; if (a_out_mispredict !== v[i].misp) begin n_err++; $display("FAIL op%0d_mispredict: got %b want %b", i, a_out_mispredict, v[i].misp); end
      n_cmp++; if (a_out_redirect_pc !== v[i].redir) begin n_err++; $display("FAIL op%0d_redirect: got %h want %h", i, a_out_redirect_pc, v[i].redir); end
      n_cmp++; if (a_out_misaligned !== v[i].mis_a) begin n_err++; $display("FAIL op%0d_misaligned_a: got %b want %b", i, a_out_misaligned, v[i].mis_a); end
      n_cmp++; if (b_out_misaligned !== v[i].mis_b) begin n_err++; $display("FAIL op%0d_misaligned_b: got %b want %b", i, b_out_misaligned, v[i].mis_b); end
      n_cmp++; if (a_out_illegal !== v[i].ill) begin n_err++; $display("FAIL op%0d_illegal: got %b want %b", i, a_out_illegal, v[i].ill); end
      n_cmp++; if (a_out_rob_entry !== 8'(8'h20 + i)) begin n_err++; $display("FAIL op%0d_rob: got %h want %h", i, a_out_rob_entry, 8'(8'h20 + i)); end
      step();
      if (v[i].cfi) begin
        exp_bc++;
        if (v[i].misp) exp_mc++;
      end
      n_cmp++; if (a_branch_count !== 32'(exp_bc)) begin n_err++; $display("FAIL op%0d_branch_count: got %0d want %0d", i, a_branch_count, exp_bc); end
      n_cmp++; if (a_mispredict_count !== 32'(exp_mc)) begin n_err++; $display("FAIL op%0d_mispredict_count: got %0d want %0d", i, a_mispredict_count, exp_mc); end
      n_cmp++; if (b_branch_count !== sat4(exp_bc)) begin n_err++; $display("FAIL op%0d_branch_count_b: got %0d want %0d", i, b_branch_count, sat4(exp_bc)); end
    end
  endtask

  task automatic drive_b2b(input int i);
    set_op(UOP_JAL, 32'h0, 32'h0, 32'(i + 1) * 32'h1000, 32'h10, 1'b0, 1'b1,
           32'(i + 1) * 32'h1000 + 32'h10, 8'(8'h40 + i));
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int next_in = 2;
    logic acc;
    out_ready = 1'b1;
    drive_b2b(0);
    in_valid = 1'b1;
    step();
    drive_b2b(1);
    step();
    out_ready = 1'b0;
    drive_b2b(2);
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_full: got %b want 0", a_in_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_rob_entry !== 8'h40 || a_out_target !== 32'h1010) begin
        n_err++; $display("FAIL b2b_stall_hold: got v=%b rob=%h tgt=%h want v=1 rob=40 tgt=1010", a_out_valid, a_out_rob_entry, a_out_target);
      end
      n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_in_ready: got %b want 0", a_in_ready); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && k < 4; c++) begin
      #1;
      if (a_out_valid) begin
        n_cmp++; if (a_out_rob_entry !== 8'(8'h40 + k) || a_out_target !== 32'(k + 1) * 32'h1000 + 32'h10) begin
          n_err++; $display("FAIL b2b_order%0d: got rob=%h tgt=%h want rob=%h", k, a_out_rob_entry, a_out_target, 8'(8'h40 + k));
        end
        k++;
      end
      acc = in_valid && a_in_ready;
      step();
      if (acc) begin
        next_in++;
        if (next_in < 4) drive_b2b(next_in);
        else in_valid = 1'b0;
      end
    end
    n_cmp++; if (k !== 4) begin n_err++; $display("FAIL b2b_delivered: got %0d want 4", k); end
    exp_bc += 4;
    n_cmp++; if (a_branch_count !== 32'(exp_bc)) begin n_err++; $display("FAIL b2b_branch_count: got %0d want %0d", a_branch_count, exp_bc); end
    n_cmp++; if (b_branch_count !== sat4(exp_bc)) begin n_err++; $display("FAIL b2b_branch_count_b: got %0d want %0d", b_branch_count, sat4(exp_bc)); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    set_op(UOP_BEQ, 32'd1, 32'd1, 32'h3000, 32'h8, 1'b0, 1'b0, 32'h0, 8'h60);
    in_valid = 1'b1;
    step();
    set_op(UOP_BEQ, 32'd1, 32'd1, 32'h3000, 32'h8, 1'b0, 1'b0, 32'h0, 8'h61);
    step();
    out_ready = 1'b0;
    set_op(UOP_BEQ, 32'd1, 32'd1, 32'h3000, 32'h8, 1'b0, 1'b0, 32'h0, 8'h62);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_branch_count !== 32'(exp_bc) || a_mispredict_count !== 32'(exp_mc)) begin
      n_err++; $display("FAIL flush_counters: got %0d/%0d want %0d/%0d", a_branch_count, a_mispredict_count, exp_bc, exp_mc);
    end
    out_ready = 1'b1;
    step(); step();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_s1_empty: got %b want 0", a_out_valid); end
    // consume during flush counts, same-cycle input is dropped
    set_op(UOP_JAL, 32'h0, 32'h0, 32'h3100, 32'h20, 1'b0, 1'b1, 32'h3120, 8'h70);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    set_op(UOP_JAL, 32'h0, 32'h0, 32'h3200, 32'h20, 1'b0, 1'b1, 32'h3220, 8'h71);
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin
      n_err++; $display("FAIL flush2_pre: got rdy=%b v=%b want 1/1", a_in_ready, a_out_valid);
    end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_bc++;
    n_cmp++; if (a_branch_count !== 32'(exp_bc)) begin n_err++; $display("FAIL flush2_consumed: got %0d want %0d", a_branch_count, exp_bc); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush2_out_valid: got %b want 0", a_out_valid); end
    step(); step();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush2_dropped: got %b want 0", a_out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_op(UOP_BEQ, 32'd3, 32'd3, 32'h4000, 32'h10, 1'b0, 1'b0, 32'h0, 8'(8'h78 + i));
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      exp_bc++; exp_mc++;
      n_cmp++; if (b_branch_count !== 4'hF) begin n_err++; $display("FAIL sat_branch_count_b: got %0d want 15", b_branch_count); end
      n_cmp++; if (a_branch_count !== 32'(exp_bc)) begin n_err++; $display("FAIL sat_branch_count_a: got %0d want %0d", a_branch_count, exp_bc); end
      n_cmp++; if (b_mispredict_count !== sat4(exp_mc)) begin n_err++; $display("FAIL sat_mispredict_b: got %0d want %0d", b_mispredict_count, sat4(exp_mc)); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_op(UOP_BEQ, 32'd2, 32'd2, 32'h5000, 32'h4, 1'b0, 1'b0, 32'h0, 8'h80);
    in_valid = 1'b1;
    step();
    set_op(UOP_BEQ, 32'd2, 32'd2, 32'h5000, 32'h4, 1'b0, 1'b0, 32'h0, 8'h81);
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (a_branch_count !== 32'h0 || a_mispredict_count !== 32'h0) begin
      n_err++; $display("FAIL areset_counters_a: got %0d/%0d want 0/0", a_branch_count, a_mispredict_count);
    end
    n_cmp++; if (b_branch_count !== 4'h0 || b_mispredict_count !== 4'h0) begin
      n_err++; $display("FAIL areset_counters_b: got %0d/%0d want 0/0", b_branch_count, b_mispredict_count);
    end
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL areset_handshake: got v=%b rdy=%b want 0/1", a_out_valid, a_in_ready);
    end
    n_cmp++; if (a_out_target !== 32'h0 || a_out_rob_entry !== 8'h0) begin
      n_err++; $display("FAIL areset_data: got tgt=%h rob=%h want 0/0", a_out_target, a_out_rob_entry);
    end
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL areset_s1_cleared: got %b want 0", a_out_valid); end
    set_op(UOP_BNE, 32'd2, 32'd3, 32'h6000, 32'h40, 1'b0, 1'b1, 32'h6040, 8'h90);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_cmp++; if (a_branch_count !== 32'd1 || a_mispredict_count !== 32'd0) begin
      n_err++; $display("FAIL areset_recount: got %0d/%0d want 1/0", a_branch_count, a_mispredict_count);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_ops();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish want finish");
    $fatal(1);
  end

endmodule
